bitwise_xor_accum: RTL
======================

BITWISE_XOR_ACCUM -- requirements
Module: bitwise_xor_accum

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (1..64).
REQ-002 Parameter CNT_W, default 8, width of the frame word counter (2..16).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 in_ready  output  1  block can accept an input word this cycle.
REQ-007 in_data  input  WIDTH  data word folded into the accumulator.
REQ-008 in_last  input  1  accepted word is the final word of the current frame.
REQ-009 out_valid  output  1  frame result held on out_data/out_count.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_data  output  WIDTH  bitwise XOR of all words of the frame.
REQ-012 out_count  output  CNT_W  number of words in the frame, saturating.
REQ-013 out_parity  output  1  present only with XOR_ACCUM_PARITY_EN (see Configuration).

Function
REQ-020 Input accept = in_valid & in_ready; output handoff = out_valid & out_ready.
REQ-021 States: IDLE (accumulator empty), ACCUM (at least one word taken, no last yet), HOLD (result pending).
REQ-022 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD; no combinational path from out_ready to in_ready.
REQ-023 On accept without in_last: acc <= acc ^ in_data, cnt <= cnt+1 (saturating), state -> ACCUM.
REQ-024 On accept with in_last: out_data <= acc ^ in_data, out_count <= cnt+1 (saturating), out_valid <= 1, state -> HOLD.
REQ-025 Latency: out_valid asserted the cycle after the in_last word is accepted.
REQ-026 In HOLD, out_data/out_count/out_valid SHALL remain stable until handoff.
REQ-027 On handoff: out_valid <= 0, acc <= 0, cnt <= 0, state -> IDLE; a new word can be accepted the following cycle.
REQ-028 Counter saturates at 2^CNT_W-1; further words still fold into acc; no wrap.
REQ-029 Single-word frame (in_last on first word from IDLE): out_data = in_data, out_count = 1.
REQ-030 in_valid low: no state change in IDLE/ACCUM; in_data/in_last ignored while in_ready=0.
REQ-031 All outputs registered; out_data driven only from registers.

Reset
REQ-040 rst high SHALL force state IDLE, acc = 0, cnt = 0, out_valid = 0, out_data = 0, out_count = 0 (out_parity = 0) at the next clock edge.
REQ-041 rst overrides any simultaneous accept or handoff; a partial frame or pending result is discarded.
REQ-042 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-050 Macro XOR_ACCUM_PARITY_EN: when defined, port out_parity exists and is registered as the reduction XOR of the value loaded into out_data, updated in the same cycle and held with it.
REQ-051 When XOR_ACCUM_PARITY_EN is undefined, out_parity port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-060 WIDTH=16: words 16'haaaa, 16'h00ff(last), out_ready=1 -> out_data=16'haa55, out_count=2, out_valid one cycle after last accept.
REQ-061 Single word 16'h0f0f with in_last from IDLE -> out_data=16'h0f0f, out_count=1; with XOR_ACCUM_PARITY_EN out_parity=0.
REQ-062 Backpressure: frame 16'h0001(last), out_ready=0 for 5 cycles -> out_valid, out_data=16'h0001 stable, in_ready=0 throughout, out_parity=1 (macro on); after handoff in_ready=1 next cycle.
REQ-063 CNT_W=2: frame of 5 words 16'h0001,16'h0002,16'h0004,16'h0008,16'h0010(last) -> out_count=3 (saturated), out_data=16'h001f.
REQ-064 Reset mid-frame: accept 16'hffff, assert rst one cycle, then 16'h1234(last) -> out_data=16'h1234, out_count=1.
REQ-065 Back-to-back frames with out_ready=1: 16'h3333(last) then 16'h0f0f(last) -> results 16'h3333 and 16'h0f0f, each count 1, no accumulator carry-over.

Source files
------------

// File: rtl/bitwise_xor_accum.sv
// rtl/bitwise_xor_accum.sv - frame-wise bitwise XOR accumulator with valid/ready handshakes
//
// Purpose:
//   Folds every accepted input word of a frame into an XOR accumulator and
//   counts the words (saturating). When the in_last word is accepted, the
//   frame result is loaded into registered outputs and held until the
//   consumer takes it; only then is the next frame accepted.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept an input word (low while a result is pending)
//   in_data    input word [WIDTH-1:0]
//   in_last    accepted word closes the frame
//   out_valid  frame result held on out_data/out_count
//   out_ready  consumer takes the result
//   out_data   XOR of all frame words [WIDTH-1:0]
//   out_count  saturating number of frame words [CNT_W-1:0]
//   out_parity reduction XOR of out_data (only with XOR_ACCUM_PARITY_EN)
//
// Configuration macro: XOR_ACCUM_PARITY_EN adds the registered out_parity port.

module bitwise_xor_accum #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef XOR_ACCUM_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [WIDTH-1:0] fold;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
`ifdef XOR_ACCUM_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // in_ready is decoded from the state register only, so out_ready never
  // reaches it combinationally.
  assign in_ready = (state_q != S_HOLD);
  assign accept   = in_valid & in_ready;
  assign fold     = acc_q ^ in_data;
  // Counter sticks at all-ones instead of wrapping.
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
`ifdef XOR_ACCUM_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
`ifdef XOR_ACCUM_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
`ifdef XOR_ACCUM_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          if (in_last) begin
            // Result goes straight to the output registers; the accumulator
            // is cleared on handoff so HOLD needs nothing else.
            out_data_d  = fold;
            out_count_d = cnt_inc;
            out_valid_d = 1'b1;
`ifdef XOR_ACCUM_PARITY_EN
            parity_d    = ^fold;
`endif
            state_d     = S_HOLD;
          end else begin
            acc_d   = fold;
            cnt_d   = cnt_inc;
            state_d = S_ACCUM;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
`ifdef XOR_ACCUM_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule
